lsu_ctrl: RTL and testbench

Load/store sequencing controller between the MEM pipeline stage and the data-memory bus port. It accepts one load or store per transaction, checks alignment, and drives a word-aligned bus request with byte strobes. It waits for the bus grant and response, then returns sign- or zero-extended load data. It stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_ld_align.sv | 28 ++
 rtl/lsu_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states
// and the store lane-steering helper.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } lane_t;

  // Loads (or illegal store codes) produce no strobes and zero data.
  function automatic lane_t store_lanes(input logic        we,
                                        input logic [2:0]  func3,
                                        input logic [1:0]  off,
                                        input logic [31:0] wdata);
    lane_t l;
    l.strb = 4'b0000;
    l.data = 32'h0;
    if (we) begin
      case (func3)
        F3_SB: begin
          l.strb = 4'b0001 << off;
          l.data = {4{wdata[7:0]}};
        end
        F3_SH: begin
          l.strb = off[1] ? 4'b1100 : 4'b0011;
          l.data = {2{wdata[15:0]}};
        end
        F3_SW: begin
          l.strb = 4'b1111;
          l.data = wdata;
        end
        default: ;
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Combinational load alignment: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it according to funct3.
module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {offset, 3'b000});
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (func3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      F3_LW:   data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory bus port:
// alignment check, word-aligned bus request with strobes, response/timeout wait.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_bvalid,
  output lsu_state_t  dbg_state
);

  // Handshake: a request transfers on the clock edge where req_valid && req_ready;
  // the bus request transfers where mem_req && mem_gnt. req_valid must stay high
  // until the resp_valid cycle.
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

  lsu_state_t  state_q, state_n;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt_q;
  logic [31:0] ld_data;
  logic        accept, misaligned, illegal, busy, timeout, gnt, rsp;
  logic        done_err;
  logic [31:0] done_data;
  lane_t       lanes;

  lsu_ld_align u_ld_align (
    .func3  (func3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .data   (ld_data)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign stall      = req_valid && !resp_valid;
  assign dbg_state  = state_q;
  assign accept     = req_valid && req_ready;
  assign lanes      = store_lanes(req_we, req_func3, req_addr[1:0], req_wdata);

  assign misaligned = ((req_func3[1:0] == 2'd1) && req_addr[0]) ||
                      ((req_func3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
  assign illegal    = req_we ? (req_func3 >= 3'd3)
                             : ((req_func3 == 3'd3) || (req_func3 == 3'd6) || (req_func3 == 3'd7));

  assign busy    = (state_q == ADDR) || (state_q == WAIT);
  assign timeout = (TIMEOUT_CYC != 0) && busy && (cnt_q == TO_LIM);
  // The request is withdrawn in the timeout cycle, so a grant there is not honoured.
  assign mem_req = (state_q == ADDR) && !timeout;
  assign gnt     = mem_gnt && mem_req;
  assign rsp     = we_q ? mem_bvalid : mem_rvalid;

  always_comb begin
    state_n   = state_q;
    done_err  = 1'b0;
    done_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned || illegal) begin
            state_n  = DONE;
            done_err = 1'b1;
          end else begin
            state_n = ADDR;
          end
        end
      end
      ADDR: begin
        if (gnt && rsp) begin
          state_n   = DONE;
          done_data = we_q ? 32'h0 : ld_data;
        end else if (gnt) begin
          state_n = WAIT;
        end else if (timeout) begin
          state_n  = DONE;
          done_err = 1'b1;
        end
      end
      WAIT: begin
        if (rsp) begin
          state_n   = DONE;
          done_data = we_q ? 32'h0 : ld_data;
        end else if (timeout) begin
          state_n  = DONE;
          done_err = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      func3_q   <= 3'd0;
      off_q     <= 2'd0;
      cnt_q     <= 32'h0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
      resp_data <= 32'h0;
      resp_err  <= 1'b0;
    end else begin
      state_q   <= state_n;
      // done_* are non-zero only on a transition into DONE, so these clear themselves.
      resp_data <= done_data;
      resp_err  <= done_err;
      if (accept) begin
        we_q      <= req_we;
        func3_q   <= req_func3;
        off_q     <= req_addr[1:0];
        cnt_q     <= 32'h0;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wstrb <= lanes.strb;
        mem_wdata <= lanes.data;
      end else if (busy) begin
        cnt_q <= cnt_q + 32'h1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of single transactions plus hand-written timeout,
// stray-response and reset-in-flight sequences, with a response scoreboard.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int W = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_bvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  lsu_state_t  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_bvalid(mem_bvalid), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: every resp_valid pulse pops one expected {err, data}
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("resp_data", resp_data, e[31:0]);
        check("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus;
    logic [3:0]  strb;
    logic [31:0] ewdata;
    logic [31:0] edata;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic bus,
                              input logic [3:0] strb, input logic [31:0] ewdata,
                              input logic [31:0] edata, input logic eerr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.bus = bus; v.strb = strb; v.ewdata = ewdata; v.edata = edata; v.eerr = eerr;
    return v;
  endfunction

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    check("req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
  endtask

  // driver: one transaction with a zero-wait bus (gnt in first ADDR cycle, response next)
  task automatic run_vec(input vec_t v);
    exp_q.push_back({v.eerr, v.edata});
    drive_req(v.we, v.f3, v.addr, v.wdata);
    if (v.bus) begin
      check("mem_req_addr", {31'h0, mem_req}, 32'h1);
      check("stall_busy", {31'h0, stall}, 32'h1);
      check("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
      check("mem_we", {31'h0, mem_we}, {31'h0, v.we});
      check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, v.strb});
      check("mem_wdata", mem_wdata, v.ewdata);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("mem_req_wait", {31'h0, mem_req}, 32'h0);
      check("mem_addr_stable", mem_addr, {v.addr[31:2], 2'b00});
      mem_rdata = v.rdata;
      if (v.we) mem_bvalid = 1'b1;
      else      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_bvalid = 1'b0;
      mem_rvalid = 1'b0;
    end else begin
      check("mem_req_err", {31'h0, mem_req}, 32'h0);
    end
    check("resp_latency", {31'h0, resp_valid}, 32'h1);
    check("stall_done", {31'h0, stall}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
  endtask

  vec_t vecs[17];

  initial begin
    int n;
    logic [1:0]  o;
    logic [31:0] rd;

    vecs[0]  = mk(0, F3_LB,  32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1, 4'h0, 32'h0, 32'hFFFF_FF80, 0);
    vecs[1]  = mk(0, F3_LHU, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 4'h0, 32'h0, 32'h0000_BEEF, 0);
    vecs[2]  = mk(1, F3_SB,  32'h0000_3001, 32'h0000_00A5, 32'h0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0);
    vecs[3]  = mk(0, F3_LW,  32'h0000_4002, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
    vecs[4]  = mk(1, F3_SH,  32'h0000_5001, 32'h1234_5678, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
    vecs[5]  = mk(0, F3_LH,  32'h0000_2000, 32'h0, 32'h1234_8001, 1, 4'h0, 32'h0, 32'hFFFF_8001, 0);
    vecs[6]  = mk(0, F3_LBU, 32'h0000_1001, 32'h0, 32'h80AA_BBCC, 1, 4'h0, 32'h0, 32'h0000_00BB, 0);
    vecs[7]  = mk(1, F3_SH,  32'h0000_5002, 32'h1234_ABCD, 32'h0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0, 0);
    vecs[8]  = mk(1, F3_SW,  32'h0000_6004, 32'hDEAD_BEEF, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
    vecs[9]  = mk(0, F3_LW,  32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 4'h0, 32'h0, 32'hCAFE_F00D, 0);
    vecs[10] = mk(0, 3'd3,   32'h0000_0100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
    vecs[11] = mk(1, 3'd4,   32'h0000_0100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
    vecs[12] = mk(0, F3_LB,  32'h0000_1000, 32'h0, 32'h0000_007F, 1, 4'h0, 32'h0, 32'h0000_007F, 0);
    for (int i = 13; i < 17; i++) begin
      o  = 2'($urandom_range(0, 3));
      rd = $urandom;
      vecs[i] = mk(0, F3_LBU, {30'h0000_2800, o}, 32'h0, rd, 1, 4'h0, 32'h0,
                   {24'h0, 8'(rd >> (8 * o))}, 0);
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // timeout with no grant: mem_req held for exactly 8 cycles, then error
    exp_q.push_back({1'b1, 32'h0});
    drive_req(0, F3_LW, 32'h0000_6000, 32'h0);
    n = 0;
    for (int k = 0; k < 40 && mem_req; k++) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, 32'd8);
    check("timeout_stall", {31'h0, stall}, 32'h1);
    check("timeout_no_resp_yet", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check("timeout_resp", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;

    // response in the timeout cycle wins
    exp_q.push_back({1'b0, 32'h1357_9BDF});
    drive_req(0, F3_LW, 32'h0000_7000, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (7) @(negedge clk);
    mem_rdata  = 32'h1357_9BDF;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rsp_resp", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;

    // bvalid during a load is ignored, in ADDR and WAIT
    exp_q.push_back({1'b0, 32'h2468_ACE0});
    drive_req(0, F3_LW, 32'h0000_9000, 32'h0);
    mem_gnt    = 1'b1;
    mem_bvalid = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("stray_bvalid_resp", {31'h0, resp_valid}, 32'h0);
    check("stray_bvalid_req", {31'h0, mem_req}, 32'h0);
    mem_bvalid = 1'b0;
    mem_rdata  = 32'h2468_ACE0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("after_stray_resp", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;

    // reset while in WAIT, then a stray rvalid
    drive_req(0, F3_LW, 32'h0000_8000, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    mem_rdata  = 32'hFFFF_FFFF;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("midrst_stray_rvalid", {31'h0, resp_valid}, 32'h0);
    check("midrst_idle", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
